// File: rtl/mio_bus_responder_if.sv
// MIO request/response bus between the multi-cycle CPU (master) and its bus responder (slave).
interface mio_bus_responder_if;
    logic        cpu_mio;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mio_ready;

    modport master (
        output cpu_mio, mem_w, addr, wdata,
        input  rdata, mio_ready
    );

    modport slave (
        input  cpu_mio, mem_w, addr, wdata,
        output rdata, mio_ready
    );
endinterface

// File: rtl/mio_bus_responder.sv
// MIO bus target: word RAM, LED register, switch input and cycle counter behind programmable wait states.
// Optional feature macro MIO_BUS_ERR_EN adds the bus_err output and a sticky error register at 0xF000_000C.
module mio_bus_responder #(
    parameter int          RAM_AW      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] LED_RST     = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    mio_bus_responder_if.slave bus,
    input  logic [15:0]        sw_in,
    output logic [31:0]        led_out
`ifdef MIO_BUS_ERR_EN
    ,
    output logic               bus_err
`endif
);

    localparam int          RAM_DEPTH = 2 ** RAM_AW;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [29:0] LED_WA    = 30'h3C00_0000;
    localparam logic [29:0] SW_WA     = 30'h3C00_0001;
    localparam logic [29:0] CNT_WA    = 30'h3C00_0002;
`ifdef MIO_BUS_ERR_EN
    localparam logic [29:0] ERR_WA    = 30'h3C00_0003;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;
    typedef enum logic [2:0] {SEL_RAM, SEL_LED, SEL_SW, SEL_CNT, SEL_ERR, SEL_NONE} sel_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic        mem_w_q;
    logic [31:0] cycle_cnt;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic [31:0] ram [RAM_DEPTH];

    logic [29:0] rd_waddr;
    sel_t        rd_sel;
    sel_t        cur_sel;
    logic [31:0] rd_val;
    logic        start_resp;
    logic        commit_w;
    logic        unused_addr_lsb;

    function automatic sel_t decode(input logic [29:0] wa);
        sel_t s;
        if (wa[29:26] == 4'h0) begin
            s = SEL_RAM;
        end else begin
            case (wa)
                LED_WA:  s = SEL_LED;
                SW_WA:   s = SEL_SW;
                CNT_WA:  s = SEL_CNT;
`ifdef MIO_BUS_ERR_EN
                ERR_WA:  s = SEL_ERR;
`endif
                default: s = SEL_NONE;
            endcase
        end
        return s;
    endfunction

`ifdef MIO_BUS_ERR_EN
    logic err_q;
    logic bus_err_q;
    assign bus_err = bus_err_q;
`endif

    // With zero wait states the read is sampled straight off the bus in IDLE.
    assign rd_waddr        = (state == IDLE) ? bus.addr[31:2] : addr_q;
    assign rd_sel          = decode(rd_waddr);
    assign cur_sel         = decode(addr_q);
    assign unused_addr_lsb = ^bus.addr[1:0];

    assign start_resp = bus.cpu_mio &&
                        (((state == IDLE) && (WAIT_CYCLES == 0)) ||
                         ((state == WAIT) && (wait_cnt == 4'd0)));
    assign commit_w   = (state == RESP) && mem_w_q;

    always_comb begin
        rd_val = '0;
        case (rd_sel)
            SEL_RAM: rd_val = ram[rd_waddr[RAM_AW-1:0]];
            SEL_LED: rd_val = led_out;
            SEL_SW:  rd_val = {16'h0000, sw_in};
            SEL_CNT: rd_val = cycle_cnt;
`ifdef MIO_BUS_ERR_EN
            SEL_ERR: rd_val = {31'b0, err_q};
`endif
            default: rd_val = '0;
        endcase
    end

    assign bus.rdata     = rdata_q;
    assign bus.mio_ready = ready_q;

    // RAM contents are never reset; a reset edge only suppresses a pending write.
    always_ff @(posedge clk) begin
        if (reset && commit_w && (cur_sel == SEL_RAM)) begin
            ram[addr_q[RAM_AW-1:0]] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            led_out   <= LED_RST;
            cycle_cnt <= '0;
`ifdef MIO_BUS_ERR_EN
            err_q     <= 1'b0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_mio) begin
                        addr_q  <= bus.addr[31:2];
                        wdata_q <= bus.wdata;
                        mem_w_q <= bus.mem_w;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.cpu_mio) begin
                        state <= IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: state <= DONE;
                DONE: begin
                    if (!bus.cpu_mio) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            ready_q <= start_resp;
            if (start_resp) begin
                rdata_q <= rd_val;
            end

            // A CPU write to the counter replaces that cycle's increment.
            if (commit_w && (cur_sel == SEL_CNT)) begin
                cycle_cnt <= wdata_q;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end

            if (commit_w && (cur_sel == SEL_LED)) begin
                led_out <= wdata_q;
            end

`ifdef MIO_BUS_ERR_EN
            bus_err_q <= start_resp && (rd_sel == SEL_NONE);
            if (state == RESP) begin
                if (cur_sel == SEL_NONE) begin
                    err_q <= 1'b1;
                end else if (mem_w_q && (cur_sel == SEL_ERR)) begin
                    err_q <= 1'b0;
                end
            end
`endif
        end
    end

endmodule
